// File: rtl/cdc_pkg.sv
// cdc_pkg: shared handshake state type and default sizes for the CDC handshake transmitter
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} hs_state_t;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;
endpackage

// File: rtl/cdc_handshake_tx_sync_ff_chain.sv
// sync_ff_chain: 1-bit STAGES-deep synchronizer chain (clk, reset, d -> q), sync active-high reset to 0
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk)
    s <= reset ? '0 : {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: four-phase req/ack CDC transmitter; ports clk, reset, data_in/valid_in/ready, tx_data/tx_req/tx_ack, done, timeout_err (only when CDC_TIMEOUT_EN is defined)
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
`ifdef CDC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             done
`ifdef CDC_TIMEOUT_EN
  , output logic           timeout_err
`endif
);
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  hs_state_t state;
  logic ack_sync;
  logic expired;
  sync_ff_chain #(.STAGES(SS)) u_ack_sync (
    .clk(clk),
    .reset(reset),
    .d(tx_ack),
    .q(ack_sync)
  );
  assign ready = (state == IDLE) && !ack_sync;
`ifdef CDC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  // counter restarts whenever a phase is entered: held at 0 in IDLE and on the REQ->RELEASE step
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == IDLE || (state == REQ && ack_sync) || expired) ? '0 : cnt + 1'b1;
      timeout_err <= expired && ((state == REQ && !ack_sync) || (state == RELEASE && ack_sync));
    end
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      tx_req <= 1'b0;
      tx_data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (valid_in && ready) begin
            tx_data <= data_in;
            tx_req <= 1'b1;
            state <= REQ;
          end
        REQ:
          if (ack_sync || expired) begin
            tx_req <= 1'b0;
            state <= ack_sync ? RELEASE : IDLE;
          end
        RELEASE:
          if (!ack_sync) begin
            done <= 1'b1;
            state <= IDLE;
          end else if (expired) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed self-checking bench for cdc_handshake_tx
module tb_cdc_handshake_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready;
  logic [15:0] tx_data;
  logic tx_req;
  logic tx_ack = 1'b0;
  logic done;
  int checks = 0;
  int errors = 0;
`ifdef CDC_TIMEOUT_EN
  logic timeout_err;
  cdc_handshake_tx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready(ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .done(done), .timeout_err(timeout_err)
  );
`else
  cdc_handshake_tx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready(ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack), .done(done)
  );
`endif
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic req, input logic [15:0] data, input logic dn, input logic rdy);
    check({tag, ".tx_req"}, {31'd0, tx_req}, {31'd0, req});
    check({tag, ".tx_data"}, {16'd0, tx_data}, {16'd0, data});
    check({tag, ".done"}, {31'd0, done}, {31'd0, dn});
    check({tag, ".ready"}, {31'd0, ready}, {31'd0, rdy});
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    reset = 1'b0;
    check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("idle_hold", 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    data_in = 16'hA5C3;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    data_in = 16'h0000;
    check_out("accept1", 1'b1, 16'hA5C3, 1'b0, 1'b0);
    tick();
    tick();
    check_out("req_wait", 1'b1, 16'hA5C3, 1'b0, 1'b0);
    tx_ack = 1'b1;
    data_in = 16'h1234;
    valid_in = 1'b1;
    tick();
    check_out("ack_sync1", 1'b1, 16'hA5C3, 1'b0, 1'b0);
    tick();
    check_out("ack_sync2", 1'b1, 16'hA5C3, 1'b0, 1'b0);
    tick();
    check_out("req_fall", 1'b0, 16'hA5C3, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check_out("release_wait", 1'b0, 16'hA5C3, 1'b0, 1'b0);
    tx_ack = 1'b0;
    tick();
    check_out("ack_fall1", 1'b0, 16'hA5C3, 1'b0, 1'b0);
    tick();
    check_out("ack_fall2", 1'b0, 16'hA5C3, 1'b0, 1'b0);
    tick();
    check_out("done", 1'b0, 16'hA5C3, 1'b1, 1'b1);
    tick();
    valid_in = 1'b0;
    check_out("b2b_accept", 1'b1, 16'h1234, 1'b0, 1'b0);
    tx_ack = 1'b1;
    tick();
    tick();
    tick();
    check_out("req_fall2", 1'b0, 16'h1234, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check_out("reset_release", 1'b0, 16'h0000, 1'b0, 1'b1);
    tx_ack = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("post_reset_no_done", 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    tx_ack = 1'b1;
    tick();
    tick();
    check_out("stale_ack", 1'b0, 16'h0000, 1'b0, 1'b0);
    data_in = 16'hBEEF;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stale_ignored", 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    tx_ack = 1'b0;
    tick();
    check_out("stale_fall1", 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_out("stale_fall2", 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    valid_in = 1'b0;
    check_out("stale_accept", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_out("no_ack_wait", 1'b1, 16'hBEEF, 1'b0, 1'b0);
`ifdef CDC_TIMEOUT_EN
      check("no_ack_wait.timeout_err", {31'd0, timeout_err}, 32'd0);
`endif
    end
    tick();
`ifdef CDC_TIMEOUT_EN
    check_out("timeout", 1'b0, 16'hBEEF, 1'b0, 1'b1);
    check("timeout.timeout_err", {31'd0, timeout_err}, 32'd1);
    tick();
    check("timeout_pulse_end", {31'd0, timeout_err}, 32'd0);
    check_out("timeout_idle", 1'b0, 16'hBEEF, 1'b0, 1'b1);
`else
    check_out("no_timeout", 1'b1, 16'hBEEF, 1'b0, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
